// File: rtl/lb_pkg.sv
// Shared types and constants for the leaderboard tracker and its rank comparator.
package lb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    UPD  = 2'd2
  } state_t;

  localparam int SCORE_W_DEF   = 8;
  localparam int NUM_SLOTS     = 3;
  localparam int MAX_SCORE_DEF = 99;

  localparam logic [1:0] RANK_NONE = 2'd0;
  localparam logic [1:0] RANK_1    = 2'd1;
  localparam logic [1:0] RANK_2    = 2'd2;
  localparam logic [1:0] RANK_3    = 2'd3;

endpackage

// File: rtl/lb_rank_compare.sv
// Combinational placement of a candidate score against the top-3 table.
// Tie rule: existing entries win unless LB_TIE_NEW_FIRST_EN is defined.
module lb_rank_compare
  import lb_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic [SCORE_W-1:0]   i_cand,
  input  logic [SCORE_W-1:0]   i_lb1,
  input  logic [SCORE_W-1:0]   i_lb2,
  input  logic [SCORE_W-1:0]   i_lb3,
  input  logic [NUM_SLOTS-1:0] i_valid,
  output logic [1:0]           o_pos
);

  logic [SCORE_W-1:0]   w_lb [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_beats;

  assign w_lb[0] = i_lb1;
  assign w_lb[1] = i_lb2;
  assign w_lb[2] = i_lb3;

  // An empty slot takes any score, including zero.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_beats
`ifdef LB_TIE_NEW_FIRST_EN
    assign w_beats[gi] = ~i_valid[gi] | (i_cand >= w_lb[gi]);
`else
    assign w_beats[gi] = ~i_valid[gi] | (i_cand > w_lb[gi]);
`endif
  end

  always_comb begin
    o_pos = RANK_NONE;
    if (w_beats[0])      o_pos = RANK_1;
    else if (w_beats[1]) o_pos = RANK_2;
    else if (w_beats[2]) o_pos = RANK_3;
  end

endmodule

// File: rtl/leaderboard_tracker.sv
// Captures the final score on each game_over rising edge and inserts it into a sorted top-3 table.
// Optional macro LB_TIE_NEW_FIRST_EN lets a new tied score rank above older equal entries.
module leaderboard_tracker
  import lb_pkg::*;
#(
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_game_over,
  input  logic               i_clear,
  output logic [SCORE_W-1:0] o_lb1,
  output logic [SCORE_W-1:0] o_lb2,
  output logic [SCORE_W-1:0] o_lb3,
  output logic [1:0]         o_rank,
  output logic               o_new_record,
  output logic               o_done,
  output logic               o_busy
);

  localparam logic [SCORE_W-1:0] CLAMP = SCORE_W'(MAX_SCORE);

  state_t               r_state;
  logic                 r_go_q;
  logic [SCORE_W-1:0]   r_cand;
  logic [1:0]           r_pos;
  logic [SCORE_W-1:0]   r_lb [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_valid;
  logic [1:0]           r_rank;
  logic                 r_new_record;
  logic                 r_done;

  logic [SCORE_W-1:0]   w_clamped;
  logic [1:0]           w_pos;
  logic                 w_start;
  logic [SCORE_W-1:0]   w_lb_shift [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_valid_shift;

  assign w_clamped = (i_score > CLAMP) ? CLAMP : i_score;
  assign w_start   = i_game_over & ~r_go_q & (r_state == IDLE) & ~i_clear;

  lb_rank_compare #(.SCORE_W(SCORE_W)) u_cmp (
    .i_cand  (r_cand),
    .i_lb1   (r_lb[0]),
    .i_lb2   (r_lb[1]),
    .i_lb3   (r_lb[2]),
    .i_valid (r_valid),
    .o_pos   (w_pos)
  );

  // Slots above the insertion point hold, the inserted slot takes cand, slots below shift down.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    if (gi == 0) begin : g_head
      assign w_lb_shift[gi]    = (r_pos == 2'(gi + 1)) ? r_cand : r_lb[gi];
      assign w_valid_shift[gi] = (r_pos == 2'(gi + 1)) ? 1'b1 : r_valid[gi];
    end else begin : g_tail
      logic w_hold;
      assign w_hold            = (r_pos == RANK_NONE) || (r_pos > 2'(gi + 1));
      assign w_lb_shift[gi]    = w_hold ? r_lb[gi] :
                                 (r_pos == 2'(gi + 1)) ? r_cand : r_lb[gi - 1];
      assign w_valid_shift[gi] = w_hold ? r_valid[gi] :
                                 (r_pos == 2'(gi + 1)) ? 1'b1 : r_valid[gi - 1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_go_q       <= 1'b0;
      r_cand       <= '0;
      r_pos        <= RANK_NONE;
      r_valid      <= '0;
      r_rank       <= RANK_NONE;
      r_new_record <= 1'b0;
      r_done       <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) r_lb[i] <= '0;
    end else begin
      r_go_q       <= i_game_over;
      r_done       <= 1'b0;
      r_new_record <= 1'b0;
      if (i_clear) begin
        r_state <= IDLE;
        r_valid <= '0;
        r_rank  <= RANK_NONE;
        for (int i = 0; i < NUM_SLOTS; i++) r_lb[i] <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_cand  <= w_clamped;
              r_state <= CMP;
            end
          end
          CMP: begin
            r_pos   <= w_pos;
            r_state <= UPD;
          end
          UPD: begin
            for (int i = 0; i < NUM_SLOTS; i++) r_lb[i] <= w_lb_shift[i];
            r_valid      <= w_valid_shift;
            r_rank       <= r_pos;
            r_done       <= 1'b1;
            r_new_record <= (r_pos == RANK_1);
            r_state      <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_lb1        = r_lb[0];
  assign o_lb2        = r_lb[1];
  assign o_lb3        = r_lb[2];
  assign o_rank       = r_rank;
  assign o_new_record = r_new_record;
  assign o_done       = r_done;
  assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_leaderboard_tracker.sv
// Self-checking bench for leaderboard_tracker: directed scenarios plus random games
// against a queue-based top-3 model.
module tb_leaderboard_tracker;

  logic       clk;
  logic       rst_n;
  logic [7:0] score;
  logic       game_over;
  logic       clear;
  logic [7:0] lb1, lb2, lb3;
  logic [1:0] rank;
  logic       new_record, done, busy;

  int n_checks = 0;
  int n_errors = 0;
  int m_lb[$];

`ifdef LB_TIE_NEW_FIRST_EN
  localparam int TIE8_RANK = 2;
`else
  localparam int TIE8_RANK = 3;
`endif

  leaderboard_tracker dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_score      (score),
    .i_game_over  (game_over),
    .i_clear      (clear),
    .o_lb1        (lb1),
    .o_lb2        (lb2),
    .o_lb3        (lb3),
    .o_rank       (rank),
    .o_new_record (new_record),
    .o_done       (done),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_lb(input int idx);
    return (idx < m_lb.size()) ? m_lb[idx] : 0;
  endfunction

  // Place the clamped score into a best-first list of at most three entries.
  task automatic model_insert(input int s, output int pos);
    int c;
    c   = (s > 99) ? 99 : s;
    pos = 0;
    for (int i = 0; i < 3; i++) begin
`ifdef LB_TIE_NEW_FIRST_EN
      if (i >= m_lb.size() || c >= m_lb[i]) begin
`else
      if (i >= m_lb.size() || c > m_lb[i]) begin
`endif
        pos = i + 1;
        break;
      end
    end
    if (pos != 0) begin
      m_lb.insert(pos - 1, c);
      if (m_lb.size() > 3) void'(m_lb.pop_back());
    end
  endtask

  task automatic check_table(input string tag);
    check({tag, "_lb1"}, 32'(lb1), 32'(model_lb(0)));
    check({tag, "_lb2"}, 32'(lb2), 32'(model_lb(1)));
    check({tag, "_lb3"}, 32'(lb3), 32'(model_lb(2)));
  endtask

  // One game: rising edge at edge k, results checked after k+2, pulses gone after k+3.
  task automatic do_game(input int s, input int want_rank, input bit hold);
    int exp_rank;
    int pulses;
    logic [31:0] sv;
    sv = 32'(s);
    @(negedge clk);
    score     = sv[7:0];
    game_over = 1'b1;
    model_insert(s, exp_rank);
    @(posedge clk); #1;
    check("busy_k", 32'(busy), 1);
    @(negedge clk);
    if (!hold) game_over = 1'b0;
    @(posedge clk); #1;
    check("done_k1", 32'(done), 0);
    @(posedge clk); #1;
    check("done_k2", 32'(done), 1);
    check("rank", 32'(rank), 32'(exp_rank));
    check("new_record", 32'(new_record), (exp_rank == 1) ? 1 : 0);
    check_table("game");
    if (want_rank >= 0) check("plan_rank", 32'(rank), 32'(want_rank));
    @(posedge clk); #1;
    check("done_k3", 32'(done), 0);
    check("new_record_k3", 32'(new_record), 0);
    check("busy_k3", 32'(busy), 0);
    if (hold) begin
      pulses = 0;
      for (int i = 0; i < 96; i++) begin
        @(posedge clk); #1;
        if (done || busy) pulses++;
      end
      check("hold_single", 32'(pulses), 0);
      check_table("hold");
      @(negedge clk);
      game_over = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int tmp;
    rst_n = 1'b0; score = '0; game_over = 1'b0; clear = 1'b0;
    #1;
    check("rst_lb1", 32'(lb1), 0);
    check("rst_rank", 32'(rank), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_game(5, 1, 1'b0);
    do_game(12, 1, 1'b0);
    do_game(8, 2, 1'b0);
    check("plan_lb1", 32'(lb1), 12);
    check("plan_lb3", 32'(lb3), 5);
    do_game(3, 0, 1'b0);
    do_game(8, TIE8_RANK, 1'b0);
    check("tie_lb3", 32'(lb3), 8);
    do_game(150, 1, 1'b0);
    check("clamp_lb1", 32'(lb1), 99);
    do_game(50, 2, 1'b1);

    // Second rising edge lands while busy and must be dropped.
    @(negedge clk); score = 8'd60; game_over = 1'b1;
    model_insert(60, tmp);
    @(posedge clk);
    @(negedge clk); game_over = 1'b0;
    @(posedge clk);
    @(negedge clk); score = 8'd70; game_over = 1'b1;
    @(posedge clk); #1;
    check("busy_edge_done", 32'(done), 1);
    check("busy_edge_rank", 32'(rank), 32'(tmp));
    tmp = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (busy || done) tmp++;
    end
    check("busy_edge_ignored", 32'(tmp), 0);
    check_table("busy_edge");
    @(negedge clk); game_over = 1'b0;
    @(negedge clk);

    // clear during CMP aborts with the table wiped and no done.
    score = 8'd30; game_over = 1'b1;
    @(posedge clk);
    @(negedge clk); game_over = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    m_lb.delete();
    check("clr_busy", 32'(busy), 0);
    check("clr_rank", 32'(rank), 0);
    check_table("clr");
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1;
    check("clr_done", 32'(done), 0);
    @(posedge clk); #1;
    check("clr_done2", 32'(done), 0);
    @(negedge clk);

    do_game(77, 1, 1'b0);

    // Asynchronous reset while in UPD.
    @(negedge clk); score = 8'd40; game_over = 1'b1;
    @(posedge clk);
    @(negedge clk); game_over = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    m_lb.delete();
    check("arst_busy", 32'(busy), 0);
    check("arst_rank", 32'(rank), 0);
    check("arst_done", 32'(done), 0);
    check_table("arst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_game(0, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1;
        m_lb.delete();
        check("rnd_clr_rank", 32'(rank), 0);
        check_table("rnd_clr");
        @(negedge clk); clear = 1'b0;
      end else begin
        do_game(int'($urandom_range(0, 130)), -1, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
